// File: rtl/sr_lru_ctrl.sv
// LRU list sequencer for lru.push / lru.pop: sequential key scan, single-cycle
// parallel reorder, one-cycle response pulse with optional tail eviction.
module sr_lru_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             evict_valid,
    output logic [WIDTH-1:0] evict_data,
    output logic [CW-1:0]    count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_UPDATE,
        S_RESP
    } state_t;

    state_t                      r_state;
    logic                        r_op;
    logic [WIDTH-1:0]            r_key;
    logic [CW-1:0]               r_idx;
    logic [CW-1:0]               r_count;
    logic                        r_hit;
    logic                        r_req_ready;
    logic                        r_resp_valid;
    logic [WIDTH-1:0]            r_resp_data;
    logic                        r_evict_valid;
    logic [WIDTH-1:0]            r_evict_data;
    logic [DEPTH-1:0][WIDTH-1:0] r_entry;

    logic [DEPTH-1:0][WIDTH-1:0] w_entry_next;
    logic [DEPTH-1:0]            w_idx_sel;
    logic [DEPTH-1:0]            w_pos_sel;
    logic [DEPTH-1:0]            w_key_match;
    logic [CW-1:0]               w_pos;
    logic [CW-1:0]               w_push_lim;
    logic                        w_pos_upper_zero;
    logic                        w_pop_ok;
    logic                        w_scan_hit;
    logic                        w_full;
    logic                        w_evict;
    logic [WIDTH-1:0]            w_pop_data;
    logic [WIDTH-1:0]            w_result;

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign evict_valid = r_evict_valid;
    assign evict_data  = r_evict_data;
    assign count       = r_count;

    // A pop position with any bit set above the count width is out of range.
    assign w_pos = r_key[CW-1:0];
    generate
        if (WIDTH > CW) begin : g_upper
            assign w_pos_upper_zero = (r_key[WIDTH-1:CW] == '0);
        end else begin : g_no_upper
            assign w_pos_upper_zero = 1'b1;
        end
    endgenerate

    assign w_pop_ok   = w_pos_upper_zero && (w_pos < r_count);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_evict    = !r_hit && w_full;
    assign w_scan_hit = |(w_idx_sel & w_key_match);

    // The scan stops at the hit index or at count, so r_idx is also the
    // upper bound of the push shift; a full-list miss clamps it to the tail.
    assign w_push_lim = (r_idx == CW'(DEPTH)) ? CW'(DEPTH - 1) : r_idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] w_up;
            logic [WIDTH-1:0] w_down;
            logic             w_push_mv;
            logic             w_pop_mv;

            assign w_idx_sel[gi]   = (r_idx == CW'(gi));
            assign w_pos_sel[gi]   = (w_pos == CW'(gi));
            assign w_key_match[gi] = (r_entry[gi] == r_key);

            if (gi == 0) begin : g_head
                assign w_up      = r_key;
                assign w_push_mv = 1'b1;
            end else begin : g_body_up
                assign w_up      = r_entry[gi-1];
                assign w_push_mv = (CW'(gi) <= w_push_lim);
            end

            if (gi == DEPTH - 1) begin : g_tail
                assign w_down   = r_entry[gi];
                assign w_pop_mv = 1'b0;
            end else begin : g_body_down
                assign w_down   = r_entry[gi+1];
                assign w_pop_mv = w_pop_ok && (CW'(gi) >= w_pos);
            end

            assign w_entry_next[gi] =
                (r_state == S_UPDATE && !r_op && w_push_mv) ? w_up   :
                (r_state == S_UPDATE &&  r_op && w_pop_mv)  ? w_down :
                                                              r_entry[gi];
        end
    endgenerate

    always_comb begin
        w_pop_data = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (w_pos_sel[j]) begin
                w_pop_data = r_entry[j];
            end
        end
    end

    always_comb begin
        w_result = '0;
        if (!r_op) begin
            w_result = r_hit ? WIDTH'(r_idx) : '1;
        end else if (w_pop_ok) begin
            w_result = w_pop_data;
        end
    end

    // Entry storage carries no reset: slots at or beyond count are don't-care.
    always_ff @(posedge clk) begin
        r_entry <= w_entry_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= 1'b0;
            r_key         <= '0;
            r_idx         <= '0;
            r_count       <= '0;
            r_hit         <= 1'b0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
            r_evict_valid <= 1'b0;
            r_evict_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_op        <= req_op;
                        r_key       <= req_data;
                        r_idx       <= '0;
                        r_hit       <= 1'b0;
                        r_req_ready <= 1'b0;
                        r_state     <= req_op ? S_UPDATE : S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_idx == r_count) begin
                        r_hit   <= 1'b0;
                        r_state <= S_UPDATE;
                    end else if (w_scan_hit) begin
                        r_hit   <= 1'b1;
                        r_state <= S_UPDATE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= w_result;
                    if (!r_op) begin
                        if (!r_hit && !w_full) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (w_evict) begin
                            r_evict_valid <= 1'b1;
                            r_evict_data  <= r_entry[DEPTH-1];
                        end
                    end else if (w_pop_ok) begin
                        r_count <= r_count - 1'b1;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_resp_valid  <= 1'b0;
                    r_evict_valid <= 1'b0;
                    r_req_ready   <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_lru_ctrl.sv
// Directed bench for sr_lru_ctrl (DEPTH=4): expected responses are queued when a
// request is driven and compared with immediate assertions when the pulse arrives.
module tb_sr_lru_ctrl;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_op = 1'b0;
    logic [WIDTH-1:0] req_data = '0;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_data;
    logic             evict_valid;
    logic [WIDTH-1:0] evict_data;
    logic [CW-1:0]    count;

    sr_lru_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_data    (req_data),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .evict_valid (evict_valid),
        .evict_data  (evict_data),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        ev;
        logic [31:0] ev_data;
        int          lat;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic queue_exp(input logic [31:0] data, input logic ev, input logic [31:0] evd,
                             input int lat, input logic [2:0] cnt);
        exp_t e;
        e.data = data; e.ev = ev; e.ev_data = evd; e.lat = lat; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic expect_resp(input string tag, input int lat_obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL %s: response with no queued expectation, got data %h", tag, resp_data);
            return;
        end
        e = sb.pop_front();
        $display("txn %s: data=%h evict=%0b/%h lat=%0d count=%0d", tag, resp_data,
                 evict_valid, evict_data, lat_obs, count);
        check({tag, " data"}, resp_data, e.data);
        check({tag, " evict_valid"}, {31'd0, evict_valid}, {31'd0, e.ev});
        if (e.ev) check({tag, " evict_data"}, evict_data, e.ev_data);
        check({tag, " latency"}, lat_obs, e.lat);
        check({tag, " count"}, {29'd0, count}, {29'd0, e.cnt});
    endtask

    // Called at a falling edge while the DUT is idle.
    task automatic do_op(input string tag, input logic op, input logic [31:0] data,
                         input logic [31:0] exp_data, input logic exp_ev,
                         input logic [31:0] exp_evd, input int exp_lat, input logic [2:0] exp_cnt);
        int t;
        int lat;
        queue_exp(exp_data, exp_ev, exp_evd, exp_lat, exp_cnt);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = ~op;
        req_data  = ~data;
        lat = 1;
        while (!resp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        expect_resp(tag, lat);
        @(negedge clk);
        check({tag, " pulse_end"}, {31'd0, resp_valid}, 32'd0);
        check({tag, " ready_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    initial begin
        logic exp_ready [9];
        int   n_acc;
        int   n_resp;
        int   acc_c;

        exp_ready = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset evict_valid", {31'd0, evict_valid}, 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        check("reset evict_data", evict_data, 32'd0);
        check("reset count", {29'd0, count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fill without eviction, then reorder on hit, then evict on full miss.
        do_op("push5",  1'b0, 32'd5, ONES,  1'b0, 32'd0, 3, 3'd1);
        do_op("push6",  1'b0, 32'd6, ONES,  1'b0, 32'd0, 4, 3'd2);
        do_op("push7",  1'b0, 32'd7, ONES,  1'b0, 32'd0, 5, 3'd3);
        do_op("push5h", 1'b0, 32'd5, 32'd2, 1'b0, 32'd0, 5, 3'd3);
        do_op("push8",  1'b0, 32'd8, ONES,  1'b0, 32'd0, 6, 3'd4);
        do_op("push9",  1'b0, 32'd9, ONES,  1'b1, 32'd6, 7, 3'd4);

        // Order now 9,8,5,7.
        do_op("pop1",     1'b1, 32'd1,     32'd8, 1'b0, 32'd0, 2, 3'd3);
        do_op("pop3_oor", 1'b1, 32'd3,     32'd0, 1'b0, 32'd0, 2, 3'd3);
        do_op("pop100",   1'b1, 32'h100,   32'd0, 1'b0, 32'd0, 2, 3'd3);
        do_op("pop8_up",  1'b1, 32'h8,     32'd0, 1'b0, 32'd0, 2, 3'd3);

        // Order 9,5,7: hit at the tail, then hit at the head.
        do_op("push7_tail", 1'b0, 32'd7, 32'd2, 1'b0, 32'd0, 5, 3'd3);
        do_op("push7_head", 1'b0, 32'd7, 32'd0, 1'b0, 32'd0, 3, 3'd3);

        // Order 7,9,5: drain from the tail and head.
        do_op("pop2_last", 1'b1, 32'd2, 32'd5, 1'b0, 32'd0, 2, 3'd2);
        do_op("pop0_a",    1'b1, 32'd0, 32'd7, 1'b0, 32'd0, 2, 3'd1);
        do_op("pop0_b",    1'b1, 32'd0, 32'd9, 1'b0, 32'd0, 2, 3'd0);
        do_op("pop_empty", 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 2, 3'd0);

        // Held request: two accepts with one idle cycle between operations.
        queue_exp(ONES,  1'b0, 32'd0, 3, 3'd1);
        queue_exp(32'd0, 1'b0, 32'd0, 3, 3'd1);
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_data  = 32'hA;
        n_acc  = 0;
        n_resp = 0;
        acc_c  = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) req_valid = 1'b0;
            check($sformatf("hold ready c%0d", c), {31'd0, req_ready}, {31'd0, exp_ready[c]});
            if (req_valid && req_ready) begin
                n_acc++;
                acc_c = c;
            end
            if (resp_valid) begin
                n_resp++;
                expect_resp($sformatf("hold resp%0d", n_resp), c - acc_c);
            end
            if (c < 8) @(negedge clk);
        end
        check("hold accepts", n_acc, 32'd2);
        check("hold responses", n_resp, 32'd2);
        do_op("pop_hold", 1'b1, 32'd0, 32'hA, 1'b0, 32'd0, 2, 3'd0);

        // Reset in the middle of a push scan on a 3-entry list.
        do_op("push1", 1'b0, 32'd1, ONES, 1'b0, 32'd0, 3, 3'd1);
        do_op("push2", 1'b0, 32'd2, ONES, 1'b0, 32'd0, 4, 3'd2);
        do_op("push3", 1'b0, 32'd3, ONES, 1'b0, 32'd0, 5, 3'd3);
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_data  = 32'd4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst count", {29'd0, count}, 32'd0);
        check("midrst req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_resp = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid) n_resp++;
        end
        check("midrst no_resp", n_resp, 32'd0);
        do_op("midrst pop0",  1'b1, 32'd0,  32'd0, 1'b0, 32'd0, 2, 3'd0);
        do_op("midrst push",  1'b0, 32'h77, ONES,  1'b0, 32'd0, 3, 3'd1);

        check("scoreboard drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
